// File: rtl/tape_sdadc_pkg.sv
// tape_sdadc_pkg: shared widths, midscale and the saturating window-count helper
package tape_sdadc_pkg;
   localparam int SAMPLE_W = 8;
   localparam logic [SAMPLE_W-1:0] MIDSCALE = 8'h80;
   // A full window of ones (2^DEC_LOG2) does not fit the sample width; clamp it to full scale.
   function automatic logic [SAMPLE_W-1:0] sat_raw(input int unsigned ones_total);
      return (ones_total >= 2 ** SAMPLE_W) ? '1 : SAMPLE_W'(ones_total);
   endfunction
endpackage

// File: rtl/tape_sdadc_sd_boxcar_decim.sv
// sd_boxcar_decim: comparator synchronizer, modulator tick, boxcar ones counter and RC feedback
module sd_boxcar_decim
   import tape_sdadc_pkg::*;
#(
   parameter int CE_DIV_LOG2 = 3,
   parameter int DEC_LOG2    = 8
) (
   input  logic                clk24,
   input  logic                reset,
   input  logic                i_cmp,
   output logic                o_fb,
   output logic [SAMPLE_W-1:0] raw,
   output logic                raw_stb
);
   logic                   s1, cmp_s;
   logic [CE_DIV_LOG2-1:0] div;
   logic [DEC_LOG2-1:0]    tick;
   logic [DEC_LOG2:0]      ones, ones_total;
   logic                   ce, close;
   always_comb begin
      ce         = div == '0;
      close      = ce && tick == '1;
      ones_total = ones + {{DEC_LOG2{1'b0}}, cmp_s};
   end
   always_ff @(posedge clk24) begin
      if (reset) begin
         s1      <= 1'b0;
         cmp_s   <= 1'b0;
         div     <= '0;
         tick    <= '0;
         ones    <= '0;
         o_fb    <= 1'b0;
         raw     <= '0;
         raw_stb <= 1'b0;
      end else begin
         s1      <= i_cmp;
         cmp_s   <= s1;
         div     <= div + 1'b1;
         raw_stb <= close;
         if (ce) begin
            o_fb <= cmp_s;
            tick <= tick + 1'b1;
            ones <= close ? '0 : ones_total;
         end
         if (close) raw <= sat_raw(32'(ones_total));
      end
   end
endmodule

// File: rtl/tape_sdadc.sv
// tape_sdadc: sigma-delta ADC receive path with moving-average PCM and hysteretic tape slicer
module tape_sdadc
   import tape_sdadc_pkg::*;
#(
   parameter int CE_DIV_LOG2 = 3,
   parameter int DEC_LOG2    = 8,
   parameter int AVG_LOG2    = 2,
   parameter int HYST        = 4
) (
   input  logic                clk24,
   input  logic                reset,
   input  logic                i_cmp,
   output logic                o_fb,
   output logic [SAMPLE_W-1:0] sample,
   output logic                sample_stb,
   output logic                tapein,
   output logic                tape_edge
);
   localparam int AVG_N = 2 ** AVG_LOG2;
   localparam int SUM_W = SAMPLE_W + AVG_LOG2;
   localparam logic [SAMPLE_W-1:0] HI = SAMPLE_W'(int'(MIDSCALE) + HYST);
   localparam logic [SAMPLE_W-1:0] LO = SAMPLE_W'(int'(MIDSCALE) - HYST);
   logic [SAMPLE_W-1:0] raw;
   logic                raw_stb;
   logic [SAMPLE_W-1:0] hist [AVG_N];
   logic [SUM_W-1:0]    sum, sum_next;
   logic                flip;
   sd_boxcar_decim #(
      .CE_DIV_LOG2(CE_DIV_LOG2),
      .DEC_LOG2   (DEC_LOG2)
   ) u_decim (
      .clk24  (clk24),
      .reset  (reset),
      .i_cmp  (i_cmp),
      .o_fb   (o_fb),
      .raw    (raw),
      .raw_stb(raw_stb)
   );
   // Running sum of the last AVG_N windows: add the newest, drop the oldest.
   always_comb begin
      sum_next = sum + SUM_W'(raw) - SUM_W'(hist[AVG_N-1]);
      flip     = sample_stb && (tapein ? sample < LO : sample > HI);
   end
   always_ff @(posedge clk24) begin
      if (reset) begin
         for (int i = 0; i < AVG_N; i++) hist[i] <= '0;
         sum        <= '0;
         sample     <= '0;
         sample_stb <= 1'b0;
         tapein     <= 1'b0;
         tape_edge  <= 1'b0;
      end else begin
         sample_stb <= raw_stb;
         if (raw_stb) begin
            sum     <= sum_next;
            sample  <= SAMPLE_W'(sum_next >> AVG_LOG2);
            hist[0] <= raw;
            for (int i = 1; i < AVG_N; i++) hist[i] <= hist[i-1];
         end
         tapein    <= tapein ^ flip;
         tape_edge <= flip;
      end
   end
endmodule

// File: tb/tb_tape_sdadc.sv
// tb_tape_sdadc: cycle-indexed reference model plus directed scenarios for tape_sdadc
module tb_tape_sdadc;
   logic       clk24 = 1'b0, reset = 1'b1, i_cmp = 1'b0;
   logic       o_fb, sample_stb, tapein, tape_edge;
   logic [7:0] sample;
   int pass_cnt = 0, chk_cnt = 0;
   int n = 0, ones = 0, c;
   int raws [4];
   int e_fb = 0, e_smp = 0, e_stb = 0, e_tap = 0, e_edge = 0;
   bit icmp_end [0:131071];
   int mode = 0, kval = 0, step_at = 0;
   int stb_cyc [$];
   int stb_val [$];
   int edge_cnt = 0, edge_cyc = -1, fb_hi = 0, fb_bad = 0, fb_a = -1, fb_b = -1, fb_prev = 0;

   always #5 clk24 = ~clk24;

   tape_sdadc dut (
      .clk24     (clk24),
      .reset     (reset),
      .i_cmp     (i_cmp),
      .o_fb      (o_fb),
      .sample    (sample),
      .sample_stb(sample_stb),
      .tapein    (tapein),
      .tape_edge (tape_edge)
   );

   task automatic check(input string name, input int act, input int exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, n);
   endtask

   // Model: n indexes cycles since reset release; cmp_s in cycle n is i_cmp captured two edges earlier.
   always @(posedge clk24) begin
      if (reset) begin
         n = 0; ones = 0;
         foreach (raws[i]) raws[i] = 0;
         e_fb = 0; e_smp = 0; e_stb = 0; e_tap = 0; e_edge = 0;
      end else begin
         icmp_end[n] = i_cmp;
         c = (n >= 2) ? int'(icmp_end[n-2]) : 0;
         e_edge = 0;
         if (e_stb == 1 && ((e_tap == 0 && e_smp > 132) || (e_tap == 1 && e_smp < 124))) begin
            e_tap = 1 - e_tap;
            e_edge = 1;
         end
         if (n % 8 == 0) begin
            e_fb = c;
            ones += c;
         end
         if (n % 2048 == 2040) begin
            raws[3] = raws[2]; raws[2] = raws[1]; raws[1] = raws[0];
            raws[0] = (ones > 255) ? 255 : ones;
            ones = 0;
         end
         n++;
         e_stb = (n % 2048 == 2042) ? 1 : 0;
         if (e_stb == 1) e_smp = (raws[0] + raws[1] + raws[2] + raws[3]) / 4;
      end
      #1;
      check("o_fb", int'(o_fb), e_fb);
      check("sample_stb", int'(sample_stb), e_stb);
      check("sample", int'(sample), e_smp);
      check("tapein", int'(tapein), e_tap);
      check("tape_edge", int'(tape_edge), e_edge);
      if (sample_stb) begin
         stb_cyc.push_back(n);
         stb_val.push_back(int'(sample));
      end
      if (tape_edge) begin
         edge_cnt++;
         if (edge_cyc < 0) edge_cyc = n;
      end
      if (o_fb) fb_hi++;
      if (!reset && n > 0 && int'(o_fb) != fb_prev && (n - 1) % 8 != 0) fb_bad++;
      fb_prev = int'(o_fb);
      if (n == 1008) fb_a = int'(o_fb);
      if (n == 1009) fb_b = int'(o_fb);
   end

   function automatic logic drive(input int cyc);
      case (mode)
         1:       return 1'b1;
         2:       return logic'(((cyc + 2) >> 3) & 1);
         3:       return (((cyc + 2) >> 3) % 256) < kval;
         4:       return cyc >= step_at;
         default: return 1'b0;
      endcase
   endfunction

   task automatic run(input int cycles);
      repeat (cycles) begin
         @(negedge clk24);
         i_cmp = drive(n);
      end
   endtask

   task automatic rst_pulse();
      @(negedge clk24);
      reset = 1'b1;
      @(negedge clk24);
      reset = 1'b0;
   endtask

   task automatic clear_logs();
      stb_cyc.delete();
      stb_val.delete();
      edge_cnt = 0; edge_cyc = -1; fb_hi = 0; fb_bad = 0; fb_a = -1; fb_b = -1;
   endtask

   function automatic int val(input int i);
      return (i < stb_val.size()) ? stb_val[i] : -1;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < stb_cyc.size()) ? stb_cyc[i] : -1;
   endfunction

   initial begin
      int exp1 [5] = '{63, 127, 191, 255, 255};
      repeat (3) @(negedge clk24);
      // constant ones
      mode = 1;
      rst_pulse();
      check("reset_sample", int'(sample), 0);
      check("reset_tapein", int'(tapein), 0);
      clear_logs();
      run(5 * 2048);
      check("t1_stb_count", stb_cyc.size(), 5);
      check("t1_first_stb", cyc_at(0), 2042);
      check("t1_second_stb", cyc_at(1), 4090);
      for (int i = 0; i < 5; i++) check("t1_sample_seq", val(i), exp1[i]);
      check("t1_edge_count", edge_cnt, 1);
      check("t1_edge_cycle", edge_cyc, 6139);
      check("t1_tapein", int'(tapein), 1);
      // constant zeros
      mode = 0;
      rst_pulse();
      clear_logs();
      run(3 * 2048);
      check("t2_stb_count", stb_cyc.size(), 3);
      for (int i = 0; i < 3; i++) check("t2_sample_zero", val(i), 0);
      check("t2_fb_high_cycles", fb_hi, 0);
      check("t2_edge_count", edge_cnt, 0);
      // 50% toggle
      mode = 2;
      rst_pulse();
      clear_logs();
      run(6 * 2048);
      check("t3_sample_w0", val(0), 32);
      check("t3_sample_w3", val(3), 128);
      check("t3_sample_w5", val(5), 128);
      check("t3_edge_count", edge_cnt, 0);
      // hysteresis thresholds
      mode = 3;
      kval = 132;
      rst_pulse();
      clear_logs();
      run(5 * 2048);
      check("t4_132_sample", val(4), 132);
      check("t4_132_tapein", int'(tapein), 0);
      check("t4_132_edges", edge_cnt, 0);
      kval = 133;
      run(4 * 2048);
      check("t4_133_sample", val(8), 133);
      check("t4_133_tapein", int'(tapein), 1);
      check("t4_133_edges", edge_cnt, 1);
      kval = 124;
      run(5 * 2048);
      check("t4_124_sample", val(13), 124);
      check("t4_124_tapein", int'(tapein), 1);
      check("t4_124_edges", edge_cnt, 1);
      kval = 123;
      run(4 * 2048);
      check("t4_123_sample", val(14), 123);
      check("t4_123_tapein", int'(tapein), 0);
      check("t4_123_edges", edge_cnt, 2);
      // reset mid-window
      mode = 1;
      rst_pulse();
      run(2 * 2048 + 800);
      rst_pulse();
      check("t5_rst_fb", int'(o_fb), 0);
      check("t5_rst_sample", int'(sample), 0);
      check("t5_rst_stb", int'(sample_stb), 0);
      check("t5_rst_tapein", int'(tapein), 0);
      check("t5_rst_edge", int'(tape_edge), 0);
      clear_logs();
      run(2048);
      check("t5_stb_count", stb_cyc.size(), 1);
      check("t5_first_stb", cyc_at(0), 2042);
      check("t5_first_sample", val(0), 63);
      // step on i_cmp
      mode = 4;
      step_at = 1003;
      rst_pulse();
      clear_logs();
      run(1100);
      check("t6_fb_before_ce", fb_a, 0);
      check("t6_fb_after_ce", fb_b, 1);
      check("t6_fb_off_ce_changes", fb_bad, 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
